// File: rtl/duc_hop_scheduler_if.sv
// Hop scheduler port bundle: table config, sequence control, DDS hop outputs.
// Latency: none; wires only.
// Backpressure: none; the sample strobe is a pacing input, not a handshake.
interface duc_hop_scheduler_if #(
  parameter int PWIDTH = 23,
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              i_cfg_wr;
  logic [AW-1:0]     i_cfg_addr;
  logic [PWIDTH-1:0] i_cfg_inc;
  logic [DWIDTH-1:0] i_cfg_dwell;
  logic [AW-1:0]     i_last_idx;
  logic              i_loop;
  logic              i_start;
  logic              i_stop;
  logic              i_sample_strobe;
  logic [PWIDTH-1:0] o_phase_start;
  logic [PWIDTH-1:0] o_phase_increment;
  logic              o_dds_reload;
  logic [AW-1:0]     o_hop_idx;
  logic              o_busy;
  logic              o_done;

  // Host / stimulus side
  modport master (
    output i_cfg_wr, i_cfg_addr, i_cfg_inc, i_cfg_dwell, i_last_idx, i_loop,
           i_start, i_stop, i_sample_strobe,
    input  o_phase_start, o_phase_increment, o_dds_reload, o_hop_idx, o_busy, o_done
  );

  // Scheduler side
  modport slave (
    input  i_cfg_wr, i_cfg_addr, i_cfg_inc, i_cfg_dwell, i_last_idx, i_loop,
           i_start, i_stop, i_sample_strobe,
    output o_phase_start, o_phase_increment, o_dds_reload, o_hop_idx, o_busy, o_done
  );
endinterface

// File: rtl/duc_hop_scheduler.sv
// Frequency-hop sequencer: walks a (phase increment, dwell) table and reloads the DDS per hop.
// Latency: o_dds_reload pulses one cycle after the LOAD cycle, i.e. two edges after i_start is sampled.
// Backpressure: none; dwell counts only cycles with i_sample_strobe, i_stop aborts immediately.
// Optional: DUC_HOP_PHASE_CONT_EN enables a phase accumulator for phase-continuous hops.
module duc_hop_scheduler #(
  parameter int PWIDTH = 23,
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 16
) (
  input logic                 i_clock,
  input logic                 i_reset_n,
  duc_hop_scheduler_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [PWIDTH-1:0] inc_tbl   [DEPTH];
  logic [DWIDTH-1:0] dwell_tbl [DEPTH];
  logic [AW-1:0]     idx;
  logic [DWIDTH-1:0] dwell_cnt;
  logic [PWIDTH-1:0] phase_start_q, phase_inc_q, load_start;
  logic [AW-1:0]     hop_idx_q;
  logic              reload_q;
  logic              busy, done;
  logic              start_ok, expire, at_last;

  assign start_ok = bus.i_start && !bus.i_stop;
  // Dwell expires on the strobe that would take the counter from 1 to 0
  assign expire   = bus.i_sample_strobe && (dwell_cnt == DWIDTH'(1));
  assign at_last  = (idx == bus.i_last_idx);

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; stop overrides everything and returns to IDLE
  always_comb begin
    state_nxt = state;
    if (bus.i_stop) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.i_start) state_nxt = S_LOAD;
        S_LOAD: state_nxt = S_RUN;
        S_RUN:  if (expire) state_nxt = (!at_last || bus.i_loop) ? S_LOAD : S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_LOAD, S_RUN: busy = 1'b1;
      S_DONE:        done = 1'b1;
      default:       ;
    endcase
  end

  // Hop table; writes land at the edge, so a same-cycle LOAD sees the old entry
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inc_tbl[i]   <= '0;
        dwell_tbl[i] <= '0;
      end
    end else if (bus.i_cfg_wr) begin
      inc_tbl[bus.i_cfg_addr]   <= bus.i_cfg_inc;
      dwell_tbl[bus.i_cfg_addr] <= bus.i_cfg_dwell;
    end
  end

`ifdef DUC_HOP_PHASE_CONT_EN
  logic [PWIDTH-1:0] phase_acc;

  // Track the DDS phase so each hop starts where the previous one left off
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)
      phase_acc <= '0;
    else if (state == S_IDLE && start_ok)
      phase_acc <= '0;
    else if (state == S_RUN && !bus.i_stop && bus.i_sample_strobe)
      phase_acc <= phase_acc + phase_inc_q;
  end

  assign load_start = phase_acc;
`else
  // Every hop restarts the DDS at phase zero
  assign load_start = '0;
`endif

  // Index, dwell counter and registered DDS outputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx           <= '0;
      dwell_cnt     <= '0;
      phase_start_q <= '0;
      phase_inc_q   <= '0;
      hop_idx_q     <= '0;
      reload_q      <= 1'b0;
    end else begin
      reload_q <= 1'b0;
      case (state)
        S_IDLE: if (start_ok) idx <= '0;
        S_LOAD: if (!bus.i_stop) begin
          phase_inc_q   <= inc_tbl[idx];
          phase_start_q <= load_start;
          reload_q      <= 1'b1;
          dwell_cnt     <= (dwell_tbl[idx] == '0) ? DWIDTH'(1) : dwell_tbl[idx];
          hop_idx_q     <= idx;
        end
        S_RUN: if (!bus.i_stop && bus.i_sample_strobe) begin
          dwell_cnt <= dwell_cnt - DWIDTH'(1);
          if (expire) begin
            if (!at_last)        idx <= idx + AW'(1);
            else if (bus.i_loop) idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_phase_start     = phase_start_q;
  assign bus.o_phase_increment = phase_inc_q;
  assign bus.o_dds_reload      = reload_q;
  assign bus.o_hop_idx         = hop_idx_q;
  assign bus.o_busy            = busy;
  assign bus.o_done            = done;
endmodule

// File: tb/tb_duc_hop_scheduler.sv
// Directed bench for duc_hop_scheduler: hop timing, looping, stop, dwell edge cases, table writes.
// Latency: checks reload two edges after start and four-cycle hop spacing at dwell 3.
// Backpressure: strobe pacing exercised with continuous and 1-in-4 patterns.
module tb_duc_hop_scheduler;
  logic i_clock = 1'b0;
  logic i_reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef DUC_HOP_PHASE_CONT_EN
  localparam logic [31:0] EXP_PS1 = 32'h3000;
  localparam logic [31:0] EXP_PSA = 32'h500;
  localparam logic [31:0] EXP_PSB = 32'h4FD;
`else
  localparam logic [31:0] EXP_PS1 = 32'h0;
  localparam logic [31:0] EXP_PSA = 32'h0;
  localparam logic [31:0] EXP_PSB = 32'h0;
`endif

  duc_hop_scheduler_if #(.PWIDTH(23), .DEPTH(8), .DWIDTH(16)) bus ();

  duc_hop_scheduler #(.PWIDTH(23), .DEPTH(8), .DWIDTH(16)) dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clock = ~i_clock;

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [22:0] inc, input logic [15:0] dw);
    bus.i_cfg_wr    = 1'b1;
    bus.i_cfg_addr  = a;
    bus.i_cfg_inc   = inc;
    bus.i_cfg_dwell = dw;
    step();
    bus.i_cfg_wr    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ps"},     32'(bus.o_phase_start),     32'h0);
    chk({tag, "_inc"},    32'(bus.o_phase_increment), 32'h0);
    chk({tag, "_reload"}, 32'(bus.o_dds_reload),      32'h0);
    chk({tag, "_hop"},    32'(bus.o_hop_idx),         32'h0);
    chk({tag, "_busy"},   32'(bus.o_busy),            32'h0);
    chk({tag, "_done"},   32'(bus.o_done),            32'h0);
  endtask

  task automatic start_seq();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  initial begin
    int cnt;
    int found;
    i_reset_n           = 1'b0;
    bus.i_cfg_wr        = 1'b0;
    bus.i_cfg_addr      = '0;
    bus.i_cfg_inc       = '0;
    bus.i_cfg_dwell     = '0;
    bus.i_last_idx      = '0;
    bus.i_loop          = 1'b0;
    bus.i_start         = 1'b0;
    bus.i_stop          = 1'b0;
    bus.i_sample_strobe = 1'b0;

    // Reset state
    #2;
    chk_all_zero("reset");
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    step();

    // Two-entry non-loop sequence, strobe every cycle
    cfg_wr(3'd0, 23'h1000, 16'd3);
    cfg_wr(3'd1, 23'h2000, 16'd2);
    bus.i_last_idx      = 3'd1;
    bus.i_loop          = 1'b0;
    bus.i_sample_strobe = 1'b1;
    start_seq();
    chk("load_busy",      32'(bus.o_busy),       32'h1);
    chk("load_no_reload", 32'(bus.o_dds_reload), 32'h0);
    step();
    chk("hop0_reload", 32'(bus.o_dds_reload),      32'h1);
    chk("hop0_inc",    32'(bus.o_phase_increment), 32'h1000);
    chk("hop0_idx",    32'(bus.o_hop_idx),         32'h0);
    chk("hop0_ps",     32'(bus.o_phase_start),     32'h0);
    repeat (3) step();
    chk("dwell_no_reload", 32'(bus.o_dds_reload), 32'h0);
    step();
    chk("hop1_reload", 32'(bus.o_dds_reload),      32'h1);
    chk("hop1_inc",    32'(bus.o_phase_increment), 32'h2000);
    chk("hop1_idx",    32'(bus.o_hop_idx),         32'h1);
    chk("hop1_ps",     32'(bus.o_phase_start),     EXP_PS1);
    step();
    chk("pre_done", 32'(bus.o_done), 32'h0);
    step();
    chk("done_pulse", 32'(bus.o_done), 32'h1);
    chk("done_busy",  32'(bus.o_busy), 32'h0);
    step();
    chk("post_done",     32'(bus.o_done),            32'h0);
    chk("post_busy",     32'(bus.o_busy),            32'h0);
    chk("post_inc_hold", 32'(bus.o_phase_increment), 32'h2000);

    // Looping sequence then stop mid-dwell
    bus.i_loop = 1'b1;
    start_seq();
    step();
    chk("loop_a_idx", 32'(bus.o_hop_idx), 32'h0);
    repeat (4) step();
    chk("loop_b_reload", 32'(bus.o_dds_reload), 32'h1);
    chk("loop_b_idx",    32'(bus.o_hop_idx),    32'h1);
    repeat (3) step();
    chk("loop_c_reload", 32'(bus.o_dds_reload), 32'h1);
    chk("loop_c_idx",    32'(bus.o_hop_idx),    32'h0);
    repeat (4) step();
    chk("loop_d_reload", 32'(bus.o_dds_reload), 32'h1);
    chk("loop_d_idx",    32'(bus.o_hop_idx),    32'h1);
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    chk("stop_busy",     32'(bus.o_busy),            32'h0);
    chk("stop_inc_hold", 32'(bus.o_phase_increment), 32'h2000);
    cnt = 0;
    repeat (6) begin
      step();
      if (bus.o_dds_reload) cnt++;
    end
    chk("stop_no_reload", 32'(cnt),             32'h0);
    chk("stop_idle_busy", 32'(bus.o_busy),      32'h0);

    // Table write during RUN on entry 0 affects next LOAD of entry 1
    bus.i_loop = 1'b0;
    start_seq();
    step();
    bus.i_cfg_wr    = 1'b1;
    bus.i_cfg_addr  = 3'd1;
    bus.i_cfg_inc   = 23'h3000;
    bus.i_cfg_dwell = 16'd2;
    step();
    bus.i_cfg_wr = 1'b0;
    repeat (3) step();
    chk("wr_run_reload", 32'(bus.o_dds_reload),      32'h1);
    chk("wr_run_inc",    32'(bus.o_phase_increment), 32'h3000);
    repeat (3) step();

    // Write coincident with LOAD of the same entry reads the old value
    start_seq();
    repeat (4) step();
    bus.i_cfg_wr    = 1'b1;
    bus.i_cfg_addr  = 3'd1;
    bus.i_cfg_inc   = 23'h4000;
    bus.i_cfg_dwell = 16'd2;
    step();
    bus.i_cfg_wr = 1'b0;
    chk("wr_load_reload", 32'(bus.o_dds_reload),      32'h1);
    chk("wr_load_inc",    32'(bus.o_phase_increment), 32'h3000);
    repeat (3) step();

    // Dwell 0 behaves as dwell 1; entry 1 now carries the later write
    cfg_wr(3'd0, 23'h5000, 16'd0);
    start_seq();
    step();
    chk("dw0_inc", 32'(bus.o_phase_increment), 32'h5000);
    step();
    chk("dw0_load_gap", 32'(bus.o_dds_reload), 32'h0);
    step();
    chk("dw0_next_reload", 32'(bus.o_dds_reload),      32'h1);
    chk("dw0_next_inc",    32'(bus.o_phase_increment), 32'h4000);
    repeat (3) step();

    // 1-in-4 strobe, dwell 3: done appears 12 cycles into RUN
    cfg_wr(3'd0, 23'h1000, 16'd3);
    bus.i_last_idx      = 3'd0;
    bus.i_sample_strobe = 1'b0;
    start_seq();
    step();
    found = -1;
    for (int c = 1; c <= 40; c++) begin
      bus.i_sample_strobe = (c % 4 == 0);
      step();
      bus.i_sample_strobe = 1'b0;
      if (found < 0 && bus.o_done) found = c;
    end
    chk("sparse_strobe_cycles", 32'(found), 32'd12);

    // Phase start per hop (accumulated and wrapping when continuity is enabled)
    cfg_wr(3'd0, 23'h100, 16'd5);
    cfg_wr(3'd1, 23'h7FFFFF, 16'd3);
    bus.i_last_idx      = 3'd1;
    bus.i_loop          = 1'b1;
    bus.i_sample_strobe = 1'b1;
    start_seq();
    step();
    chk("ph_a_ps", 32'(bus.o_phase_start), 32'h0);
    repeat (6) step();
    chk("ph_b_reload", 32'(bus.o_dds_reload),  32'h1);
    chk("ph_b_ps",     32'(bus.o_phase_start), EXP_PSA);
    repeat (4) step();
    chk("ph_c_idx", 32'(bus.o_hop_idx),     32'h0);
    chk("ph_c_ps",  32'(bus.o_phase_start), EXP_PSB);
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;

    // Reset mid-RUN, then a fresh start from the cleared table
    start_seq();
    repeat (2) step();
    #2 i_reset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    step();
    i_reset_n = 1'b1;
    bus.i_loop = 1'b0;
    step();
    chk("rst_idle_busy", 32'(bus.o_busy), 32'h0);
    start_seq();
    chk("rst_load_reload", 32'(bus.o_dds_reload), 32'h0);
    step();
    chk("rst_reload",     32'(bus.o_dds_reload),      32'h1);
    chk("rst_inc_clear",  32'(bus.o_phase_increment), 32'h0);
    step();
    chk("rst_reload_end", 32'(bus.o_dds_reload), 32'h0);
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
